// File: rtl/commit_monitor.sv
// Commit monitor: cycle/instret counters, halt detection (trap, timeout, hang) and heartbeat.
// Define COMMIT_HIST_EN to build the PC history ring buffer; otherwise history outputs read 0.
module commit_monitor #(
  parameter int unsigned PC_W        = 64,
  parameter int unsigned NR_COMMIT   = 2,
  parameter int unsigned MAX_CYCLES  = 400000000,
  parameter int unsigned HEARTBEAT   = 32'h300000,
  parameter int unsigned HANG_CYCLES = 100000,
  parameter int unsigned HIST_DEPTH  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NR_COMMIT-1:0]          commit_valid,
  input  logic [NR_COMMIT*PC_W-1:0]     commit_pc,
  input  logic                          ebreak,
  input  logic [PC_W-1:0]               trap_code,
  output logic                          halt_valid,
  output logic [2:0]                    halt_cause,
  output logic [63:0]                   cycle_cnt,
  output logic [63:0]                   instret_cnt,
  output logic                          heartbeat,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx,
  output logic [PC_W-1:0]               hist_rd_pc,
  output logic [$clog2(HIST_DEPTH):0]   hist_count
);
  localparam int unsigned IDX_W  = $clog2(HIST_DEPTH);
  localparam int unsigned IDLE_W = $clog2(HANG_CYCLES + 1);
  localparam int unsigned HB_W   = (HEARTBEAT > 1) ? $clog2(HEARTBEAT) : 1;
  localparam int unsigned POP_W  = $clog2(NR_COMMIT + 1);

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_GOOD    = 3'd1;
  localparam logic [2:0] CAUSE_BAD     = 3'd2;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd3;
  localparam logic [2:0] CAUSE_HANG    = 3'd4;

  typedef enum logic [1:0] {WAIT_FIRST = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_t;

  function automatic logic [POP_W-1:0] popcount(input logic [NR_COMMIT-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(NR_COMMIT); i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

  state_t              state_q, state_d;
  logic                active;
  logic [NR_COMMIT-1:0] commit_eff;
  logic                any_commit;
  logic [POP_W-1:0]    pop;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [HB_W-1:0]     hb_cnt;
  logic                ev_trap, ev_timeout, ev_hang, halt_ev;
  logic [2:0]          cause_d;

  // Inputs are masked once halted so nothing downstream sees late commits or traps
  assign commit_eff = active ? commit_valid : '0;
  assign any_commit = |commit_eff;
  assign pop        = popcount(commit_eff);

  assign ev_trap    = active && ebreak;
  assign ev_timeout = active && (cycle_cnt == 64'(MAX_CYCLES) - 64'd1);
  assign ev_hang    = (state_q == RUN) && !any_commit && (idle_cnt == IDLE_W'(HANG_CYCLES - 1));
  assign halt_ev    = ev_trap || ev_timeout || ev_hang;

  always_comb begin
    cause_d = CAUSE_NONE;
    if (ev_trap)         cause_d = (trap_code == '0) ? CAUSE_GOOD : CAUSE_BAD;
    else if (ev_timeout) cause_d = CAUSE_TIMEOUT;
    else if (ev_hang)    cause_d = CAUSE_HANG;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= WAIT_FIRST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FIRST: if (halt_ev) state_d = HALTED; else if (any_commit) state_d = RUN;
      RUN:        if (halt_ev) state_d = HALTED;
      HALTED:     state_d = HALTED;
      default:    state_d = WAIT_FIRST;
    endcase
  end

  always_comb begin
    active    = (state_q != HALTED);
    heartbeat = reset && active && (hb_cnt == HB_W'(HEARTBEAT - 1));
  end

  // Counters and sticky halt registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      idle_cnt    <= '0;
      hb_cnt      <= '0;
      halt_valid  <= 1'b0;
      halt_cause  <= CAUSE_NONE;
    end else begin
      if (active) begin
        cycle_cnt   <= cycle_cnt + 64'd1;
        instret_cnt <= instret_cnt + 64'(pop);
      end
      if (state_q == RUN) idle_cnt <= any_commit ? '0 : idle_cnt + 1'b1;
      hb_cnt <= (hb_cnt == HB_W'(HEARTBEAT - 1)) ? '0 : hb_cnt + 1'b1;
      if (halt_ev) begin
        halt_valid <= 1'b1;
        halt_cause <= cause_d;
      end
    end
  end

`ifdef COMMIT_HIST_EN
  localparam int unsigned SUM_W = IDX_W + POP_W + 1;

  function automatic logic [IDX_W:0] sat_hist(input logic [IDX_W:0] cnt, input logic [POP_W-1:0] add);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cnt) + SUM_W'(add);
    return (sum >= SUM_W'(HIST_DEPTH)) ? (IDX_W+1)'(HIST_DEPTH) : (IDX_W+1)'(sum);
  endfunction

  logic [PC_W-1:0]  hist_mem [HIST_DEPTH];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] lane_slot [NR_COMMIT];
  logic [IDX_W-1:0] rd_slot;

  // Each valid lane lands one slot after the previous valid lane
  for (genvar g = 0; g < NR_COMMIT; g++) begin : g_slot
    if (g == 0) begin : g_first
      assign lane_slot[g] = wr_ptr;
    end else begin : g_next
      assign lane_slot[g] = lane_slot[g-1] + IDX_W'(commit_eff[g-1]);
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(NR_COMMIT); i++)
      if (commit_eff[i]) hist_mem[lane_slot[i]] <= commit_pc[i*PC_W +: PC_W];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      hist_count <= '0;
    end else if (any_commit) begin
      wr_ptr     <= wr_ptr + IDX_W'(pop);
      hist_count <= sat_hist(hist_count, pop);
    end
  end

  assign rd_slot    = wr_ptr - IDX_W'(1) - hist_rd_idx;
  assign hist_rd_pc = ({1'b0, hist_rd_idx} < hist_count) ? hist_mem[rd_slot] : '0;
`else
  logic unused_hist;
  assign unused_hist = ^{hist_rd_idx, commit_pc};
  assign hist_rd_pc  = '0;
  assign hist_count  = '0;
`endif

endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench for commit_monitor: trap/timeout/hang halts, priorities, heartbeat,
// asynchronous reset and (when COMMIT_HIST_EN is defined) the PC history buffer.
module tb_commit_monitor;
  localparam int PC_W = 64;
  localparam int NR   = 2;
  localparam int HD   = 4;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [NR-1:0]         commit_valid = '0;
  logic [NR*PC_W-1:0]    commit_pc = '0;
  logic                  ebreak = 1'b0;
  logic [PC_W-1:0]       trap_code = '0;
  logic                  halt_valid;
  logic [2:0]            halt_cause;
  logic [63:0]           cycle_cnt;
  logic [63:0]           instret_cnt;
  logic                  heartbeat;
  logic [$clog2(HD)-1:0] hist_rd_idx = '0;
  logic [PC_W-1:0]       hist_rd_pc;
  logic [$clog2(HD):0]   hist_count;

  int checks = 0;
  int passed = 0;

  commit_monitor #(
    .PC_W(PC_W), .NR_COMMIT(NR), .MAX_CYCLES(50), .HEARTBEAT(4),
    .HANG_CYCLES(8), .HIST_DEPTH(HD)
  ) dut (
    .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .ebreak(ebreak), .trap_code(trap_code), .halt_valid(halt_valid), .halt_cause(halt_cause),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .heartbeat(heartbeat),
    .hist_rd_idx(hist_rd_idx), .hist_rd_pc(hist_rd_pc), .hist_count(hist_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    commit_valid = '0; commit_pc = '0; ebreak = 1'b0; trap_code = '0; hist_rd_idx = '0;
  endtask

  // Leaves the bench at a falling edge with reset just released: cycle 0
  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;
    #1;
    checks++; if (halt_valid !== 1'b0) $display("FAIL rst_halt_valid: got %0d want 0", halt_valid); else passed++;
    checks++; if (halt_cause !== 3'd0) $display("FAIL rst_halt_cause: got %0d want 0", halt_cause); else passed++;
    checks++; if (cycle_cnt !== 64'd0) $display("FAIL rst_cycle_cnt: got %0d want 0", cycle_cnt); else passed++;
    checks++; if (instret_cnt !== 64'd0) $display("FAIL rst_instret: got %0d want 0", instret_cnt); else passed++;
    checks++; if (heartbeat !== 1'b0) $display("FAIL rst_heartbeat: got %0d want 0", heartbeat); else passed++;
    checks++; if (hist_count !== '0) $display("FAIL rst_hist_count: got %0d want 0", hist_count); else passed++;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (cycle_cnt !== 64'd3) $display("FAIL rst_count_from0: got %0d want 3", cycle_cnt); else passed++;
  endtask

  task automatic test_good_trap();
    do_reset();
    commit_valid = 2'b11;
    commit_pc = {64'h2000, 64'h1000};
    repeat (10) tick();
    checks++; if (instret_cnt !== 64'd20) $display("FAIL trap_instret_pre: got %0d want 20", instret_cnt); else passed++;
    checks++; if (halt_valid !== 1'b0) $display("FAIL trap_early_halt: got %0d want 0", halt_valid); else passed++;
    ebreak = 1'b1; trap_code = '0; commit_valid = 2'b01;
    tick();
    checks++; if (halt_valid !== 1'b1) $display("FAIL trap_halt_valid: got %0d want 1", halt_valid); else passed++;
    checks++; if (halt_cause !== 3'd1) $display("FAIL trap_good_cause: got %0d want 1", halt_cause); else passed++;
    checks++; if (instret_cnt !== 64'd21) $display("FAIL trap_instret: got %0d want 21", instret_cnt); else passed++;
    checks++; if (cycle_cnt !== 64'd11) $display("FAIL trap_cycle_cnt: got %0d want 11", cycle_cnt); else passed++;
    commit_valid = 2'b11; ebreak = 1'b1; trap_code = 64'd5;
    repeat (3) tick();
    checks++; if (instret_cnt !== 64'd21) $display("FAIL halted_instret_frozen: got %0d want 21", instret_cnt); else passed++;
    checks++; if (cycle_cnt !== 64'd11) $display("FAIL halted_cycle_frozen: got %0d want 11", cycle_cnt); else passed++;
    checks++; if (halt_cause !== 3'd1) $display("FAIL halted_cause_sticky: got %0d want 1", halt_cause); else passed++;
  endtask

  task automatic test_trap_vs_timeout();
    do_reset();
    repeat (49) tick();
    checks++; if (halt_valid !== 1'b0) $display("FAIL no_hang_wait_first: got %0d want 0", halt_valid); else passed++;
    checks++; if (cycle_cnt !== 64'd49) $display("FAIL tvt_cycle_cnt: got %0d want 49", cycle_cnt); else passed++;
    ebreak = 1'b1; trap_code = 64'd5;
    tick();
    ebreak = 1'b0;
    checks++; if (halt_valid !== 1'b1) $display("FAIL tvt_halt_valid: got %0d want 1", halt_valid); else passed++;
    checks++; if (halt_cause !== 3'd2) $display("FAIL tvt_bad_trap_wins: got %0d want 2", halt_cause); else passed++;
    repeat (2) tick();
    checks++; if (cycle_cnt !== 64'd50) $display("FAIL tvt_cycle_frozen: got %0d want 50", cycle_cnt); else passed++;
  endtask

  task automatic test_hang();
    do_reset();
    repeat (3) tick();
    commit_valid = 2'b01; commit_pc = {64'h0, 64'h80};
    tick();
    commit_valid = 2'b00;
    repeat (7) tick();
    checks++; if (halt_valid !== 1'b0) $display("FAIL hang_early: got %0d want 0 at commit+8", halt_valid); else passed++;
    tick();
    checks++; if (halt_valid !== 1'b1) $display("FAIL hang_halt_valid: got %0d want 1 at commit+9", halt_valid); else passed++;
    checks++; if (halt_cause !== 3'd4) $display("FAIL hang_cause: got %0d want 4", halt_cause); else passed++;
    checks++; if (instret_cnt !== 64'd1) $display("FAIL hang_instret: got %0d want 1", instret_cnt); else passed++;
  endtask

  task automatic test_timeout_then_reset();
    do_reset();
    repeat (41) tick();
    commit_valid = 2'b10; commit_pc = {64'h44, 64'h0};
    tick();
    commit_valid = 2'b00;
    repeat (7) tick();
    checks++; if (halt_valid !== 1'b0) $display("FAIL tvh_early: got %0d want 0", halt_valid); else passed++;
    tick();
    checks++; if (halt_cause !== 3'd3) $display("FAIL tvh_timeout_wins: got %0d want 3", halt_cause); else passed++;
    checks++; if (cycle_cnt !== 64'd50) $display("FAIL tvh_cycle_cnt: got %0d want 50", cycle_cnt); else passed++;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (halt_valid !== 1'b0) $display("FAIL async_halt_valid: got %0d want 0", halt_valid); else passed++;
    checks++; if (halt_cause !== 3'd0) $display("FAIL async_halt_cause: got %0d want 0", halt_cause); else passed++;
    checks++; if (cycle_cnt !== 64'd0) $display("FAIL async_cycle_cnt: got %0d want 0", cycle_cnt); else passed++;
    checks++; if (instret_cnt !== 64'd0) $display("FAIL async_instret: got %0d want 0", instret_cnt); else passed++;
    @(negedge clock);
    reset = 1'b1;
    checks++; if (cycle_cnt !== 64'd0) $display("FAIL restart_cycle0: got %0d want 0", cycle_cnt); else passed++;
    repeat (2) tick();
    checks++; if (cycle_cnt !== 64'd2) $display("FAIL restart_cycle2: got %0d want 2", cycle_cnt); else passed++;
    checks++; if (halt_valid !== 1'b0) $display("FAIL restart_halt: got %0d want 0", halt_valid); else passed++;
  endtask

  task automatic test_heartbeat();
    logic exp_hb;
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      exp_hb = ((k % 4) == 3);
      checks++; if (heartbeat !== exp_hb) $display("FAIL hb_cycle%0d: got %0d want %0d", k, heartbeat, exp_hb); else passed++;
      if (k == 12) ebreak = 1'b1;
      tick();
    end
    ebreak = 1'b0;
    checks++; if (halt_cause !== 3'd1) $display("FAIL hb_halt_cause: got %0d want 1", halt_cause); else passed++;
    for (int k = 13; k <= 20; k++) begin
      checks++; if (heartbeat !== 1'b0) $display("FAIL hb_halted_cycle%0d: got %0d want 0", k, heartbeat); else passed++;
      tick();
    end
  endtask

  task automatic test_history();
    do_reset();
`ifdef COMMIT_HIST_EN
    checks++; if (hist_rd_pc !== 64'h0) $display("FAIL hist_empty_pc: got %0h want 0", hist_rd_pc); else passed++;
    commit_valid = 2'b11; commit_pc = {64'h14, 64'h10};
    tick();
    checks++; if (hist_count !== 3'd2) $display("FAIL hist_count2: got %0d want 2", hist_count); else passed++;
    hist_rd_idx = 2'd0; #1;
    checks++; if (hist_rd_pc !== 64'h14) $display("FAIL hist_first_idx0: got %0h want 14", hist_rd_pc); else passed++;
    hist_rd_idx = 2'd1; #1;
    checks++; if (hist_rd_pc !== 64'h10) $display("FAIL hist_first_idx1: got %0h want 10", hist_rd_pc); else passed++;
    hist_rd_idx = 2'd2; #1;
    checks++; if (hist_rd_pc !== 64'h0) $display("FAIL hist_beyond_count: got %0h want 0", hist_rd_pc); else passed++;
    commit_pc = {64'h1C, 64'h18};
    tick();
    commit_pc = {64'h24, 64'h20};
    tick();
    commit_valid = 2'b01; commit_pc = {64'hDEAD, 64'h28};
    tick();
    commit_valid = 2'b00;
    checks++; if (hist_count !== 3'd4) $display("FAIL hist_count_sat: got %0d want 4", hist_count); else passed++;
    hist_rd_idx = 2'd0; #1;
    checks++; if (hist_rd_pc !== 64'h28) $display("FAIL hist_idx0: got %0h want 28", hist_rd_pc); else passed++;
    hist_rd_idx = 2'd1; #1;
    checks++; if (hist_rd_pc !== 64'h24) $display("FAIL hist_idx1: got %0h want 24", hist_rd_pc); else passed++;
    hist_rd_idx = 2'd3; #1;
    checks++; if (hist_rd_pc !== 64'h1C) $display("FAIL hist_idx3: got %0h want 1c", hist_rd_pc); else passed++;
    commit_valid = 2'b10; commit_pc = {64'h30, 64'hBAD};
    tick();
    commit_valid = 2'b00;
    hist_rd_idx = 2'd0; #1;
    checks++; if (hist_rd_pc !== 64'h30) $display("FAIL hist_lane1_only: got %0h want 30", hist_rd_pc); else passed++;
    hist_rd_idx = 2'd3; #1;
    checks++; if (hist_rd_pc !== 64'h20) $display("FAIL hist_wrap_idx3: got %0h want 20", hist_rd_pc); else passed++;
`else
    commit_valid = 2'b11; commit_pc = {64'h14, 64'h10};
    repeat (3) tick();
    commit_valid = 2'b00;
    checks++; if (hist_count !== '0) $display("FAIL nohist_count: got %0d want 0", hist_count); else passed++;
    checks++; if (hist_rd_pc !== 64'h0) $display("FAIL nohist_pc: got %0h want 0", hist_rd_pc); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_good_trap();
    test_trap_vs_timeout();
    test_hang();
    test_timeout_then_reset();
    test_heartbeat();
    test_history();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
